// File: rtl/reg_file.sv
// reg_file: 32x64 register file with same-cycle write bypass, ALU flag latch,
// non-bypassed debug read port and a count of committed writes.
module reg_file #(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:4]       ra1,
  input  logic [0:4]       ra2,
  output logic [0:WIDTH-1] rd1,
  output logic [0:WIDTH-1] rd2,
  input  logic             we,
  input  logic [0:4]       wa,
  input  logic [0:WIDTH-1] wd,
  input  logic             flags_we,
  input  logic [0:3]       flags_in,
  output logic [0:3]       flags_q,
  input  logic [0:4]       dbg_addr,
  output logic [0:WIDTH-1] dbg_data,
  output logic [0:15]      wr_count
);
  logic [0:WIDTH-1] mem [NREGS];
  logic wr_en;
  assign wr_en = we && !rst && wa != 5'd0;
  // x0 is forced to zero on every read path, so its storage is never consulted
  always_comb begin
    rd1      = ra1 == 5'd0 ? '0 : (BYPASS && wr_en && ra1 == wa) ? wd : mem[ra1];
    rd2      = ra2 == 5'd0 ? '0 : (BYPASS && wr_en && ra2 == wa) ? wd : mem[ra2];
    dbg_data = dbg_addr == 5'd0 ? '0 : mem[dbg_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      flags_q  <= '0;
      wr_count <= '0;
    end else begin
      if (wr_en) begin
        mem[wa]  <= wd;
        wr_count <= wr_count + 16'd1;
      end
      if (flags_we) flags_q <= flags_in;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reg_file with bypass enabled and disabled.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst, we, flags_we;
  logic [0:4]  ra1, ra2, wa, dbg_addr;
  logic [0:63] wd;
  logic [0:3]  flags_in;
  logic [0:63] rd1, rd2, dbg_data, nb_rd1, nb_rd2, nb_dbg;
  logic [0:3]  flags_q, nb_flags;
  logic [0:15] wr_count, nb_count;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(64), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .flags_we(flags_we), .flags_in(flags_in),
    .flags_q(flags_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );
  reg_file #(.WIDTH(64), .NREGS(32), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .we(we), .wa(wa), .wd(wd), .flags_we(flags_we), .flags_in(flags_in),
    .flags_q(nb_flags), .dbg_addr(dbg_addr), .dbg_data(nb_dbg), .wr_count(nb_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; flags_we = 1'b0; ra1 = '0; ra2 = '0; wa = '0;
    wd = '0; flags_in = '0; dbg_addr = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_count", 64'(wr_count), 64'd0);
    // write x3 then reset with a pending write and flag update
    we = 1'b1; wa = 5'd3; wd = 64'h5;
    step();
    we = 1'b0; ra1 = 5'd3;
    #1 chk("x3_before_rst", rd1, 64'h5);
    rst = 1'b1; we = 1'b1; wa = 5'd4; wd = 64'h9; flags_we = 1'b1; flags_in = 4'hF;
    step();
    rst = 1'b0; we = 1'b0; flags_we = 1'b0; ra1 = 5'd3; ra2 = 5'd4;
    #1 chk("rst_x3", rd1, 64'd0);
    chk("rst_x4", rd2, 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_count", 64'(wr_count), 64'd0);
    // plain write/read
    we = 1'b1; wa = 5'd5; wd = 64'd105;
    step();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1 chk("wr5_rd1", rd1, 64'd105);
    chk("wr5_rd2", rd2, 64'd105);
    chk("wr5_count", 64'(wr_count), 64'd1);
    we = 1'b1; wa = 5'd6; wd = 64'd215;
    step();
    we = 1'b0; ra2 = 5'd6;
    #1 chk("wr6_rd2", rd2, 64'd215);
    chk("wr6_count", 64'(wr_count), 64'd2);
    // x0 writes are dropped and never bypassed
    we = 1'b1; wa = 5'd0; wd = '1; ra1 = 5'd0;
    #1 chk("x0_no_bypass", rd1, 64'd0);
    step();
    we = 1'b0; dbg_addr = 5'd0;
    #1 chk("x0_rd1", rd1, 64'd0);
    chk("x0_dbg", dbg_data, 64'd0);
    chk("x0_count", 64'(wr_count), 64'd2);
    // bypass vs. stored value
    we = 1'b1; wa = 5'd7; wd = 64'd10;
    step();
    wd = 64'd20; ra1 = 5'd7; ra2 = 5'd7; dbg_addr = 5'd7;
    #1 chk("byp_rd1", rd1, 64'd20);
    chk("byp_rd2", rd2, 64'd20);
    chk("byp_dbg", dbg_data, 64'd10);
    chk("nobyp_rd1", nb_rd1, 64'd10);
    chk("nobyp_rd2", nb_rd2, 64'd10);
    step();
    we = 1'b0;
    #1 chk("post_byp_rd1", rd1, 64'd20);
    chk("post_nobyp_rd1", nb_rd1, 64'd20);
    chk("post_byp_count", 64'(wr_count), 64'd4);
    // X on idle write and flag inputs must not disturb state
    wa = 'x; wd = 'x; flags_in = 'x;
    step();
    chk("x_idle_dbg", dbg_data, 64'd20);
    chk("x_idle_count", 64'(wr_count), 64'd4);
    chk("x_idle_flags", 64'(flags_q), 64'd0);
    // flags
    flags_we = 1'b1; flags_in = 4'b0100;
    step();
    chk("flags_set", 64'(flags_q), 64'h4);
    flags_we = 1'b0; flags_in = 4'b1001;
    step();
    chk("flags_hold", 64'(flags_q), 64'h4);
    // simultaneous write and flag update
    we = 1'b1; wa = 5'd8; wd = 64'd77; flags_we = 1'b1; flags_in = 4'b1001;
    step();
    we = 1'b0; flags_we = 1'b0; dbg_addr = 5'd8;
    #1 chk("both_dbg", dbg_data, 64'd77);
    chk("both_flags", 64'(flags_q), 64'h9);
    chk("both_count", 64'(wr_count), 64'd5);
    // drive wr_count to 0xFFFF, then wrap
    we = 1'b1; wa = 5'd1;
    for (int i = 0; i < 65530; i++) begin
      wd = 64'(i);
      step();
    end
    chk("count_ffff", 64'(wr_count), 64'hFFFF);
    wd = 64'hDEAD_BEEF_0123_4567;
    step();
    we = 1'b0; dbg_addr = 5'd1;
    #1 chk("count_wrap", 64'(wr_count), 64'd0);
    chk("nb_count_wrap", 64'(nb_count), 64'd0);
    chk("wrap_x1", dbg_data, 64'hDEAD_BEEF_0123_4567);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
